// File: rtl/seg7_scan_decoder_pkg.sv
// rtl/seg7_scan_decoder_pkg.sv - shared seven-segment bit positions, BCD patterns and error code
package seg7_scan_decoder_pkg;

  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  // Patterns are active-high, bit position = segment index above
  localparam logic [6:0] PAT_0 = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) | (1 << SEG_D) | (1 << SEG_E) | (1 << SEG_F));
  localparam logic [6:0] PAT_1 = 7'((1 << SEG_B) | (1 << SEG_C));
  localparam logic [6:0] PAT_2 = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_D) | (1 << SEG_E) | (1 << SEG_G));
  localparam logic [6:0] PAT_3 = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) | (1 << SEG_D) | (1 << SEG_G));
  localparam logic [6:0] PAT_4 = 7'((1 << SEG_B) | (1 << SEG_C) | (1 << SEG_F) | (1 << SEG_G));
  localparam logic [6:0] PAT_5 = 7'((1 << SEG_A) | (1 << SEG_C) | (1 << SEG_D) | (1 << SEG_F) | (1 << SEG_G));
  localparam logic [6:0] PAT_6 = 7'((1 << SEG_A) | (1 << SEG_C) | (1 << SEG_D) | (1 << SEG_E) | (1 << SEG_F) | (1 << SEG_G));
  localparam logic [6:0] PAT_7 = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C));
  localparam logic [6:0] PAT_8 = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) | (1 << SEG_D) | (1 << SEG_E) | (1 << SEG_F) | (1 << SEG_G));
  localparam logic [6:0] PAT_9 = 7'((1 << SEG_A) | (1 << SEG_B) | (1 << SEG_C) | (1 << SEG_D) | (1 << SEG_F) | (1 << SEG_G));

  localparam logic [6:0] PAT_BLANK = 7'b000_0000;
  localparam logic [3:0] ERR_CODE  = 4'hF;

endpackage

// File: rtl/seg7_pattern_decode.sv
// rtl/seg7_pattern_decode.sv - combinational 7-segment pattern to BCD value plus error flag
module seg7_pattern_decode (
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       err
);
  import seg7_scan_decoder_pkg::*;

  always_comb begin
    value = 4'd0;
    err   = 1'b0;
    case (pattern)
      PAT_0:     value = 4'd0;
      PAT_1:     value = 4'd1;
      PAT_2:     value = 4'd2;
      PAT_3:     value = 4'd3;
      PAT_4:     value = 4'd4;
      PAT_5:     value = 4'd5;
      PAT_6:     value = 4'd6;
      PAT_7:     value = 4'd7;
      PAT_8:     value = 4'd8;
      PAT_9:     value = 4'd9;
      PAT_BLANK: value = 4'd0;
      default: begin
        value = ERR_CODE;
        err   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - reconstructs four BCD digits by snooping a multiplexed 7-segment scan
module seg7_scan_decoder #(
  parameter int SETTLE_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES   = 2000000,
  parameter int SEG_ACTIVE_LOW   = 1,
  parameter int DIGIT_ACTIVE_LOW = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] SEG,
  input  logic [3:0] DIGIT,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic [3:0] thousands,
  output logic [3:0] dp,
  output logic [3:0] digit_err,
  output logic       frame_valid,
  output logic       frame_stable,
  output logic       scan_lost
);
  import seg7_scan_decoder_pkg::*;

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [7:0]    seg_q, seg_prev, seg_n;
  logic [3:0]    digit_q, digit_prev, digit_n;
  logic [SW-1:0] settle_cnt;
  logic [TW-1:0] timeout_cnt;
  logic [3:0]    slot_val [4];
  logic [3:0]    slot_dp, slot_err, mask;
  logic          prev_valid;
  logic          one_hot, stable, capture, frame_done, timeout_hit, frame_match;
  logic [3:0]    dec_val;
  logic          dec_err;

  assign seg_n   = (SEG_ACTIVE_LOW != 0)   ? ~seg_q   : seg_q;
  assign digit_n = (DIGIT_ACTIVE_LOW != 0) ? ~digit_q : digit_q;

  assign one_hot = (digit_n != 4'd0) && ((digit_n & (digit_n - 4'd1)) == 4'd0);
  assign stable  = (seg_q == seg_prev) && (digit_q == digit_prev);
  // Counter saturates one past the capture point, so each dwell yields one capture
  assign capture     = one_hot && stable && (settle_cnt == SW'(SETTLE_CYCLES - 1));
  assign frame_done  = (mask == 4'b1111);
  assign timeout_hit = !capture && (timeout_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign frame_match = ({slot_val[3], slot_val[2], slot_val[1], slot_val[0], slot_dp, slot_err} ==
                        {thousands, hundreds, tens, units, dp, digit_err});

  seg7_pattern_decode u_decode (
    .pattern (seg_n[6:0]),
    .value   (dec_val),
    .err     (dec_err)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      seg_q        <= '0;
      seg_prev     <= '0;
      digit_q      <= '0;
      digit_prev   <= '0;
      settle_cnt   <= '0;
      timeout_cnt  <= '0;
      for (int i = 0; i < 4; i++) slot_val[i] <= '0;
      slot_dp      <= '0;
      slot_err     <= '0;
      mask         <= '0;
      prev_valid   <= 1'b0;
      units        <= '0;
      tens         <= '0;
      hundreds     <= '0;
      thousands    <= '0;
      dp           <= '0;
      digit_err    <= '0;
      frame_valid  <= 1'b0;
      frame_stable <= 1'b0;
      scan_lost    <= 1'b0;
    end else begin
      seg_q      <= SEG;
      digit_q    <= DIGIT;
      seg_prev   <= seg_q;
      digit_prev <= digit_q;

      if (!one_hot || !stable) settle_cnt <= '0;
      else if (settle_cnt != SW'(SETTLE_CYCLES)) settle_cnt <= settle_cnt + 1'b1;

      for (int i = 0; i < 4; i++) begin
        if (capture && digit_n[i]) begin
          slot_val[i] <= dec_val;
          slot_dp[i]  <= seg_n[SEG_DP];
          slot_err[i] <= dec_err;
        end
      end

      if (capture) timeout_cnt <= '0;
      else if (timeout_cnt != TW'(TIMEOUT_CYCLES)) timeout_cnt <= timeout_cnt + 1'b1;

      if (timeout_hit)     mask <= '0;
      else if (frame_done) mask <= capture ? digit_n : 4'd0;
      else if (capture)    mask <= mask | digit_n;

      // Outputs copy the slots as they stood before any same-cycle capture
      frame_valid <= frame_done;
      if (frame_done) begin
        units        <= slot_val[0];
        tens         <= slot_val[1];
        hundreds     <= slot_val[2];
        thousands    <= slot_val[3];
        dp           <= slot_dp;
        digit_err    <= slot_err;
        frame_stable <= prev_valid && frame_match;
        prev_valid   <= 1'b1;
      end else if (timeout_hit) begin
        frame_stable <= 1'b0;
      end

      if (capture)          scan_lost <= 1'b0;
      else if (timeout_hit) scan_lost <= 1'b1;
    end
  end

endmodule
